arp_resolve_ctrl: RTL and testbench
===================================

Name: arp_resolve_ctrl

Overview:
- Sequences next-hop MAC resolution for two TX-path requesters (req0 = TCP TX, req1 = UDP/ICMP TX) against the shared 5-entry ARP cache.
- Arbitrates between the requesters round-robin and drives the cache lookup port.
- On a miss, issues an ARP request to the ARP TX builder, waits for the reply with timeout and retry, then writes the result into the cache.
- Forwards every received ARP reply into the cache write port.

Parameters:
- TIMEOUT_CYCLES, 1000000: cycles spent in WAIT_REPLY before a retry; must be ≥2.
- MAX_RETRY, 3: ARP requests sent per miss before reporting failure; must be ≥1.

Ports:
- i_sys_clk  in  1  system clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_req0_valid  in  1  requester 0 resolve request; held until its o_resp_valid[0]
- i_req0_ip  in  32  requester 0 target IP; stable while valid
- i_req1_valid  in  1  requester 1 resolve request; held until its o_resp_valid[1]
- i_req1_ip  in  32  requester 1 target IP; stable while valid
- o_resp_valid  out  2  one-cycle response pulse, one-hot per requester
- o_resp_hit  out  1  1 = resolved, 0 = failed; valid with o_resp_valid
- o_resp_mac  out  48  resolved MAC; 0 on failure
- o_lookup_en  out  1  cache lookup enable
- o_lookup_ip  out  32  cache lookup IP
- i_lookup_done  in  1  cache lookup done (combinational, same cycle)
- i_lookup_result  in  1  cache hit
- i_lookup_mac  in  48  cache MAC
- o_cache_w_en  out  1  cache write strobe
- o_cache_w_ip  out  32  cache write IP
- o_cache_w_mac  out  48  cache write MAC
- o_arp_req_valid  out  1  ARP request to TX builder
- o_arp_req_ip  out  32  ARP request target IP
- i_arp_req_ready  in  1  TX builder accepts the request
- i_arp_rx_valid  in  1  one-cycle pulse: parsed ARP reply
- i_arp_rx_ip  in  32  sender IP of the reply
- i_arp_rx_mac  in  48  sender MAC of the reply

Behaviour:
- Reset:
  - All outputs 0.
  - FSM returns to IDLE; retry count 0; timer 0.
  - Round-robin pointer set so that req0 has priority.
  - Reset asserted mid-operation aborts the operation; no response is issued.
- FSM states: IDLE, LOOKUP, SEND_REQ, WAIT_REPLY, RESPOND.
- IDLE:
  - If any i_reqN_valid is high, grant one requester; on a tie, grant the one the round-robin pointer favours.
  - Latch the granted index and IP, then go to LOOKUP.
  - After each grant, the pointer moves to favour the other requester.
- LOOKUP (one cycle):
  - o_lookup_en = 1 and o_lookup_ip = latched IP; sample i_lookup_*.
  - If i_arp_rx_valid is high with i_arp_rx_ip equal to the latched IP, treat it as a hit using i_arp_rx_mac; this takes priority over the cache result.
  - Hit → RESPOND with hit = 1 and the MAC.
  - Miss → retry count = 0, go to SEND_REQ.
- SEND_REQ:
  - o_arp_req_valid = 1 and o_arp_req_ip = latched IP.
  - On the cycle with valid && i_arp_req_ready: retry count + 1, timer cleared, go to WAIT_REPLY.
  - A matching reply arriving here → RESPOND with hit = 1, and o_arp_req_valid drops.
- WAIT_REPLY:
  - Timer increments each cycle.
  - Matching i_arp_rx_valid → RESPOND with hit = 1 and the reply MAC.
  - Timer reaches TIMEOUT_CYCLES-1 with no match:
    - If retry count < MAX_RETRY → SEND_REQ.
    - Otherwise → RESPOND with hit = 0 and MAC = 0.
  - A matching reply in the same cycle as timer expiry wins: hit.
  - Non-matching replies do not change state.
- RESPOND (one cycle):
  - o_resp_valid[granted] = 1 with o_resp_hit and o_resp_mac; other cycles hold these at 0.
  - Next state IDLE.
  - A requester whose request is still held is not re-granted in the cycle after its response; requesters deassert valid the cycle after the response.
- Cache write path, independent of the FSM:
  - Every i_arp_rx_valid pulse is registered to o_cache_w_en = 1 one cycle later, with o_cache_w_ip/o_cache_w_mac set to that reply's IP/MAC.
  - Otherwise o_cache_w_en = 0.
  - Back-to-back pulses give back-to-back writes.
- Latencies from request to response:
  - Cache hit: IDLE grant → LOOKUP → RESPOND, so o_resp_valid rises 3 cycles after i_reqN_valid is first sampled high in IDLE.
  - No holes in TX builder readiness: failure takes MAX_RETRY × (TIMEOUT_CYCLES + 1) + 3 cycles.

Test Plan:
- Cache preloaded with 10.0.0.2→02:00:00:00:00:02; req0 ip=10.0.0.2 → o_resp_valid=2'b01, hit=1, mac=0x020000000002 three cycles after request; no o_arp_req_valid.
- Miss on req1 ip=10.0.0.9, TIMEOUT_CYCLES=16, i_arp_req_ready=1; inject reply 10.0.0.9/0xAABBCCDDEEFF 5 cycles into WAIT_REPLY → exactly one o_arp_req_valid; o_resp_valid=2'b10, hit=1, that MAC; o_cache_w_en pulse 1 cycle after the reply with the same IP/MAC.
- Miss with no reply, TIMEOUT_CYCLES=16, MAX_RETRY=3 → three ARP requests spaced 17 cycles apart; response hit=0, mac=0 at cycle 3×17+3.
- req0 and req1 both valid from reset, both hits → req0 served first, then req1; repeated simultaneous requests alternate 0,1,0,1.
- In WAIT_REPLY inject non-matching reply 10.0.0.7 → cache write occurs, no response; matching reply on the exact expiry cycle → hit=1, no retry.
- Deassert i_rstn while in WAIT_REPLY → all outputs 0 immediately; after release, a new req0 hit completes normally in 3 cycles.

Source files
------------

// File: rtl/arp_resolve_ctrl.sv
// Next-hop MAC resolution sequencer: round-robin over two TX requesters, cache lookup,
// ARP request/timeout/retry on a miss, and forwarding of every received ARP reply to the cache.
module arp_resolve_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        i_sys_clk,
    input  logic        i_rstn,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_ip,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_ip,
    output logic [1:0]  o_resp_valid,
    output logic        o_resp_hit,
    output logic [47:0] o_resp_mac,
    output logic        o_lookup_en,
    output logic [31:0] o_lookup_ip,
    input  logic        i_lookup_done,
    input  logic        i_lookup_result,
    input  logic [47:0] i_lookup_mac,
    output logic        o_cache_w_en,
    output logic [31:0] o_cache_w_ip,
    output logic [47:0] o_cache_w_mac,
    output logic        o_arp_req_valid,
    output logic [31:0] o_arp_req_ip,
    input  logic        i_arp_req_ready,
    input  logic        i_arp_rx_valid,
    input  logic [31:0] i_arp_rx_ip,
    input  logic [47:0] i_arp_rx_mac
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOOKUP     = 3'd1;
    localparam logic [2:0] SEND_REQ   = 3'd2;
    localparam logic [2:0] WAIT_REPLY = 3'd3;
    localparam logic [2:0] RESPOND    = 3'd4;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    logic [2:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic [31:0]   ip_q, ip_d;
    logic          rr_q, rr_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          hit_q, hit_d;
    logic [47:0]   mac_q, mac_d;
    logic          block_q, block_d;
    logic          cw_en_q;
    logic [31:0]   cw_ip_q;
    logic [47:0]   cw_mac_q;

    logic rx_match;
    logic v0, v1, pick;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ip_d     = ip_q;
        rr_d     = rr_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        hit_d    = hit_q;
        mac_d    = mac_q;
        block_d  = 1'b0;
        rx_match = i_arp_rx_valid && (i_arp_rx_ip == ip_q);
        // The requester just answered may still hold valid for one cycle; mask it out.
        v0       = i_req0_valid && !(block_q && !gnt_q);
        v1       = i_req1_valid && !(block_q && gnt_q);
        pick     = (v0 && v1) ? rr_q : v1;
        case (state_q)
            IDLE: begin
                if (v0 || v1) begin
                    gnt_d   = pick;
                    ip_d    = pick ? i_req1_ip : i_req0_ip;
                    rr_d    = ~pick;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (rx_match) begin
                    hit_d   = 1'b1;
                    mac_d   = i_arp_rx_mac;
                    state_d = RESPOND;
                end else if (i_lookup_done && i_lookup_result) begin
                    hit_d   = 1'b1;
                    mac_d   = i_lookup_mac;
                    state_d = RESPOND;
                end else begin
                    retry_d = '0;
                    state_d = SEND_REQ;
                end
            end
            SEND_REQ: begin
                if (rx_match) begin
                    hit_d   = 1'b1;
                    mac_d   = i_arp_rx_mac;
                    state_d = RESPOND;
                end else if (i_arp_req_ready) begin
                    retry_d = retry_q + RW'(1);
                    timer_d = '0;
                    state_d = WAIT_REPLY;
                end
            end
            WAIT_REPLY: begin
                timer_d = timer_q + TW'(1);
                if (rx_match) begin
                    hit_d   = 1'b1;
                    mac_d   = i_arp_rx_mac;
                    state_d = RESPOND;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        state_d = SEND_REQ;
                    end else begin
                        hit_d   = 1'b0;
                        mac_d   = '0;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                block_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            ip_q    <= '0;
            rr_q    <= 1'b0;
            retry_q <= '0;
            timer_q <= '0;
            hit_q   <= 1'b0;
            mac_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ip_q    <= ip_d;
            rr_q    <= rr_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            hit_q   <= hit_d;
            mac_q   <= mac_d;
            block_q <= block_d;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cw_en_q  <= 1'b0;
            cw_ip_q  <= '0;
            cw_mac_q <= '0;
        end else begin
            cw_en_q <= i_arp_rx_valid;
            if (i_arp_rx_valid) begin
                cw_ip_q  <= i_arp_rx_ip;
                cw_mac_q <= i_arp_rx_mac;
            end
        end
    end

    assign o_resp_valid    = (state_q == RESPOND) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_resp_hit      = (state_q == RESPOND) && hit_q;
    assign o_resp_mac      = (state_q == RESPOND) ? mac_q : '0;
    assign o_lookup_en     = (state_q == LOOKUP);
    assign o_lookup_ip     = (state_q == LOOKUP) ? ip_q : '0;
    assign o_arp_req_valid = (state_q == SEND_REQ);
    assign o_arp_req_ip    = (state_q == SEND_REQ) ? ip_q : '0;
    assign o_cache_w_en    = cw_en_q;
    assign o_cache_w_ip    = cw_ip_q;
    assign o_cache_w_mac   = cw_mac_q;

endmodule

// File: tb/tb_arp_resolve_ctrl.sv
// Bench for arp_resolve_ctrl: behavioural cache, response and cache-write scoreboards,
// a vector table of single requests and hand-written multi-cycle sequences.
module tb_arp_resolve_ctrl;

    localparam int unsigned T  = 16;
    localparam int unsigned MR = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_ip = '0, req1_ip = '0;
    logic [1:0]  o_resp_valid;
    logic        o_resp_hit;
    logic [47:0] o_resp_mac;
    logic        o_lookup_en;
    logic [31:0] o_lookup_ip;
    logic        lk_done, lk_hit;
    logic [47:0] lk_mac;
    logic        o_cache_w_en;
    logic [31:0] o_cache_w_ip;
    logic [47:0] o_cache_w_mac;
    logic        o_arp_req_valid;
    logic [31:0] o_arp_req_ip;
    logic        arp_ready = 1'b1;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_ip = '0;
    logic [47:0] rx_mac = '0;

    always #5 clk = ~clk;

    arp_resolve_ctrl #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .i_sys_clk(clk), .i_rstn(rstn),
        .i_req0_valid(req0_valid), .i_req0_ip(req0_ip),
        .i_req1_valid(req1_valid), .i_req1_ip(req1_ip),
        .o_resp_valid(o_resp_valid), .o_resp_hit(o_resp_hit), .o_resp_mac(o_resp_mac),
        .o_lookup_en(o_lookup_en), .o_lookup_ip(o_lookup_ip),
        .i_lookup_done(lk_done), .i_lookup_result(lk_hit), .i_lookup_mac(lk_mac),
        .o_cache_w_en(o_cache_w_en), .o_cache_w_ip(o_cache_w_ip), .o_cache_w_mac(o_cache_w_mac),
        .o_arp_req_valid(o_arp_req_valid), .o_arp_req_ip(o_arp_req_ip), .i_arp_req_ready(arp_ready),
        .i_arp_rx_valid(rx_valid), .i_arp_rx_ip(rx_ip), .i_arp_rx_mac(rx_mac)
    );

    // Preloaded cache: 10.0.0.2 .. 10.0.0.6 -> 02:00:00:00:00:0N
    always_comb begin
        lk_done = o_lookup_en;
        lk_hit  = 1'b0;
        lk_mac  = '0;
        if (o_lookup_en) begin
            case (o_lookup_ip)
                32'h0A000002: begin lk_hit = 1'b1; lk_mac = 48'h020000000002; end
                32'h0A000003: begin lk_hit = 1'b1; lk_mac = 48'h020000000003; end
                32'h0A000004: begin lk_hit = 1'b1; lk_mac = 48'h020000000004; end
                32'h0A000005: begin lk_hit = 1'b1; lk_mac = 48'h020000000005; end
                32'h0A000006: begin lk_hit = 1'b1; lk_mac = 48'h020000000006; end
                default: ;
            endcase
        end
    end

    int errors = 0;
    int checks = 0;
    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    typedef struct { int idx; logic hit; logic [47:0] mac; } resp_t;
    typedef struct { logic [31:0] ip; logic [47:0] mac; int due; } wr_t;
    typedef struct { int idx; logic [31:0] ip; logic hit; logic [47:0] mac; int lat; int arps; } vec_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    arp_times[$];
    resp_t e;
    wr_t   w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic hit, input logic [47:0] mac);
        resp_t r;
        r.idx = idx; r.hit = hit; r.mac = mac;
        exp_q.push_back(r);
    endtask

    task automatic pulse_rx(input logic [31:0] ip, input logic [47:0] mac);
        wr_t x;
        x.ip = ip; x.mac = mac; x.due = gcyc + 1;
        wr_q.push_back(x);
        rx_valid = 1'b1; rx_ip = ip; rx_mac = mac;
    endtask

    task automatic drive_req(input int idx, input logic [31:0] ip);
        if (idx == 0) begin req0_valid = 1'b1; req0_ip = ip; end
        else          begin req1_valid = 1'b1; req1_ip = ip; end
    endtask

    task automatic drop_req(input int idx);
        if (idx == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    // Requester keeps valid through the cycle following its response, then drops it.
    task automatic release_req(input int idx);
        @(negedge clk);
        @(negedge clk);
        drop_req(idx);
    endtask

    // Latency counted with the cycle the request is driven as cycle 1.
    task automatic wait_resp(input int idx, input int budget, output int lat);
        lat = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            lat++;
            if (o_resp_valid[idx]) begin
                release_req(idx);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_resp%0d: no response within %0d cycles", idx, budget);
        drop_req(idx);
        lat = -1;
    endtask

    task automatic wait_arp(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (o_arp_req_valid) return;
        end
        checks++; errors++;
        $display("FAIL wait_arp: no ARP request within %0d cycles", budget);
    endtask

    always @(negedge clk) begin
        if (o_arp_req_valid) arp_times.push_back(gcyc);
        if (o_resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", {62'd0, o_resp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_onehot", {62'd0, o_resp_valid}, (e.idx != 0) ? 64'd2 : 64'd1);
                check("resp_hit", {63'd0, o_resp_hit}, {63'd0, e.hit});
                check("resp_mac", {16'd0, o_resp_mac}, {16'd0, e.mac});
            end
        end
        if (o_cache_w_en) begin
            if (wr_q.size() == 0) begin
                check("cache_w_unexpected", {63'd0, o_cache_w_en}, 64'd0);
            end else begin
                w = wr_q.pop_front();
                check("cache_w_ip", {32'd0, o_cache_w_ip}, {32'd0, w.ip});
                check("cache_w_mac", {16'd0, o_cache_w_mac}, {16'd0, w.mac});
                check("cache_w_cycle", 64'(gcyc), 64'(w.due));
            end
        end
    end

    vec_t vt[5];
    int   lat;

    initial begin
        vt[0] = '{0, 32'h0A000002, 1'b1, 48'h020000000002, 3, 0};
        vt[1] = '{1, 32'h0A000003, 1'b1, 48'h020000000003, 3, 0};
        vt[2] = '{1, 32'h0A000002, 1'b1, 48'h020000000002, 3, 0};
        vt[3] = '{0, 32'h0A000005, 1'b1, 48'h020000000005, 3, 0};
        vt[4] = '{0, 32'h0A000014, 1'b0, 48'h0, 3 * (T + 1) + 3, 3};

        // Both requesters valid from reset
        drive_req(0, 32'h0A000002);
        drive_req(1, 32'h0A000003);
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {62'd0, o_resp_valid}, 64'd0);
        check("rst_lookup_en", {63'd0, o_lookup_en}, 64'd0);
        check("rst_arp_req", {63'd0, o_arp_req_valid}, 64'd0);
        check("rst_cache_w", {63'd0, o_cache_w_en}, 64'd0);
        check("rst_resp_mac", {16'd0, o_resp_mac}, 64'd0);
        push_exp(0, 1'b1, 48'h020000000002);
        push_exp(1, 1'b1, 48'h020000000003);
        rstn = 1'b1;
        wait_resp(0, 20, lat);
        check("tie_first_lat", 64'(lat), 64'd3);
        wait_resp(1, 20, lat);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            push_exp(0, 1'b1, 48'h020000000002);
            push_exp(1, 1'b1, 48'h020000000003);
            drive_req(0, 32'h0A000002);
            drive_req(1, 32'h0A000003);
            wait_resp(0, 20, lat);
            wait_resp(1, 20, lat);
        end

        // Vector table of single requests
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(negedge clk);
            arp_times.delete();
            push_exp(vt[i].idx, vt[i].hit, vt[i].mac);
            drive_req(vt[i].idx, vt[i].ip);
            wait_resp(vt[i].idx, 200, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("vec%0d_arps", i), 64'(arp_times.size()), 64'(vt[i].arps));
            if (arp_times.size() == 3) begin
                check("retry_gap1", 64'(arp_times[1] - arp_times[0]), 64'(T + 1));
                check("retry_gap2", 64'(arp_times[2] - arp_times[1]), 64'(T + 1));
            end
        end

        // Miss, reply arrives 5 cycles into WAIT_REPLY
        repeat (2) @(negedge clk);
        arp_times.delete();
        push_exp(1, 1'b1, 48'hAABBCCDDEEFF);
        drive_req(1, 32'h0A000009);
        wait_arp(10);
        check("arp_req_ip", {32'd0, o_arp_req_ip}, 64'h0A000009);
        repeat (5) @(negedge clk);
        pulse_rx(32'h0A000009, 48'hAABBCCDDEEFF);
        @(negedge clk);
        rx_valid = 1'b0;
        check("reply_resp", {62'd0, o_resp_valid}, 64'd2);
        release_req(1);
        check("reply_arps", 64'(arp_times.size()), 64'd1);

        // Non-matching back-to-back replies, then match on the expiry cycle
        repeat (2) @(negedge clk);
        arp_times.delete();
        push_exp(0, 1'b1, 48'h0A0B0C0D0E0F);
        drive_req(0, 32'h0A000008);
        wait_arp(10);
        repeat (3) @(negedge clk);
        pulse_rx(32'h0A000007, 48'h111111111111);
        @(negedge clk);
        pulse_rx(32'h0A000006, 48'h222222222222);
        @(negedge clk);
        rx_valid = 1'b0;
        check("nomatch_no_resp", {62'd0, o_resp_valid}, 64'd0);
        repeat (11) @(negedge clk);
        pulse_rx(32'h0A000008, 48'h0A0B0C0D0E0F);
        @(negedge clk);
        rx_valid = 1'b0;
        check("expiry_resp", {62'd0, o_resp_valid}, 64'd1);
        release_req(0);
        check("expiry_no_retry", 64'(arp_times.size()), 64'd1);

        // Matching reply while SEND_REQ is stalled by the TX builder
        repeat (2) @(negedge clk);
        arp_ready = 1'b0;
        push_exp(1, 1'b1, 48'h0000DEADBEEF);
        drive_req(1, 32'h0A00001E);
        wait_arp(10);
        repeat (3) @(negedge clk);
        check("stall_req_held", {63'd0, o_arp_req_valid}, 64'd1);
        pulse_rx(32'h0A00001E, 48'h0000DEADBEEF);
        @(negedge clk);
        rx_valid = 1'b0;
        check("stall_resp", {62'd0, o_resp_valid}, 64'd2);
        check("stall_req_dropped", {63'd0, o_arp_req_valid}, 64'd0);
        release_req(1);
        arp_ready = 1'b1;

        // Reset during WAIT_REPLY
        repeat (2) @(negedge clk);
        drive_req(0, 32'h0A000028);
        wait_arp(10);
        repeat (4) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_resp", {62'd0, o_resp_valid}, 64'd0);
        check("mid_rst_lookup", {63'd0, o_lookup_en}, 64'd0);
        check("mid_rst_arp", {63'd0, o_arp_req_valid}, 64'd0);
        check("mid_rst_arp_ip", {32'd0, o_arp_req_ip}, 64'd0);
        check("mid_rst_cache_w", {63'd0, o_cache_w_en}, 64'd0);
        drop_req(0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        arp_times.delete();
        push_exp(0, 1'b1, 48'h020000000002);
        drive_req(0, 32'h0A000002);
        wait_resp(0, 20, lat);
        check("post_rst_lat", 64'(lat), 64'd3);
        check("post_rst_arps", 64'(arp_times.size()), 64'd0);

        repeat (4) @(negedge clk);
        check("resp_sb_drained", 64'(exp_q.size()), 64'd0);
        check("cache_w_sb_drained", 64'(wr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
